// File: rtl/mips_boot_pkg.sv
// Shared boot definitions: loader state encoding, memory map bases and
// small helpers used by the instruction-memory stream loader and memory models.
// Contents: ldr_state_e, IMEM_BASE, DMEM_BASE, geometry constants, count_legal(), is_stream_state().
package mips_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } ldr_state_e;

    // Reset fetch address of the core and base of its data segment.
    localparam logic [31:0] IMEM_BASE = 32'h0040_0000;
    localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 12;  // init_address is a word index
    localparam int unsigned CNT_W      = 13;  // one extra bit so a full 4096-word image fits

    // A header word count is usable when it names at least one word and
    // no more words than the memory holds.
    function automatic logic count_legal(input logic [15:0] n, input logic [16:0] depth);
        return (n != 16'd0) && ({1'b0, n} <= depth);
    endfunction

    // States in which the loader is waiting on the byte stream.
    function automatic logic is_stream_state(input ldr_state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/imem_stream_loader_byte_packer.sv
// Packs four stream bytes MSB-first into one 32-bit instruction word.
// Ports: clk/reset_n, clear_i (restart word), byte_vld_i/byte_dat_i (accepted byte),
// word_o (shift register), word_valid_o (this byte completes the word).
module byte_packer
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // Shifting left puts the first byte of a word in [31:24] once all four
    // have arrived. The word itself is never cleared; only its index is.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_vld_i) begin
            word_d = {word_q[23:0], byte_dat_i};
            idx_d  = idx_q + 2'd1;  // wraps to 0 after the 4th byte
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    // Flags the byte that completes a word so the FSM can move to WRITE on
    // the same edge that the last byte is shifted in.
    assign word_valid_o = byte_vld_i && !clear_i && (idx_q == LAST_IDX);
    assign word_o       = word_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses a 2-byte word count, then streams 4-byte words into the
// core's instruction-memory init port, holding the core in reset until done.
// Ports: clk/reset_n, start, s_data/s_valid/s_ready (byte stream), init_mode,
// write_enable, init_address, init_instruction, core_reset, load_done, load_error.
module imem_stream_loader
    import mips_boot_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,      // must not exceed 2**ADDR_W
    parameter int unsigned TIMEOUT = 1_000_000  // idle cycles tolerated between bytes
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        init_mode,
    output logic        write_enable,
    output logic [11:0] init_address,
    output logic [31:0] init_instruction,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int unsigned     TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [16:0]     DEPTH_17 = 17'(DEPTH);

    ldr_state_e          state_q, state_d;
    logic [7:0]          hdr_hi_q, hdr_hi_d;
    logic [CNT_W-1:0]    n_q, n_d;        // words in the image
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;  // words written so far
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TO_W-1:0]     to_q, to_d;

    logic s_ready_q, write_enable_q, init_mode_q, core_reset_q, load_done_q, load_error_q;

    logic        accept;
    logic        restart;
    logic        pk_shift;
    logic        pk_word_done;
    logic        to_expired;
    logic [15:0] hdr_n;
    logic [31:0] pk_word;

    // s_ready_q always mirrors the current state, so the handshake never
    // depends combinationally on s_valid.
    assign accept     = s_valid && s_ready_q;
    assign restart    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
    assign pk_shift   = accept && (state_q == ST_DATA);
    assign hdr_n      = {hdr_hi_q, s_data};
    assign to_expired = (to_q == TO_LAST);

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (restart),
        .byte_vld_i   (pk_shift),
        .byte_dat_i   (s_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_done)
    );

    always_comb begin
        state_d  = state_q;
        hdr_hi_d = hdr_hi_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        to_d     = to_q;

        // Idle watchdog while waiting on the stream. to_q holds the number of
        // idle cycles already seen, so the TIMEOUT-th idle cycle aborts.
        if (is_stream_state(state_q)) begin
            if (accept) begin
                to_d = '0;
            end else if (to_expired) begin
                state_d = ST_ERROR;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        case (state_q)
            ST_HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = s_data;
                    state_d  = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    if (count_legal(hdr_n, DEPTH_17)) begin
                        n_d     = hdr_n[CNT_W-1:0];
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (pk_word_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wcnt_d = wcnt_q + CNT_W'(1);
                to_d   = '0;
                // The address is only advanced when another word follows, so
                // a full-depth image ends at the top address without wrapping.
                if ((wcnt_q + CNT_W'(1)) == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_DATA;
                end
            end
            default: ;
        endcase

        if (restart) begin
            state_d = ST_HDR_HI;
            n_d     = '0;
            wcnt_d  = '0;
            addr_d  = '0;
            to_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            hdr_hi_q <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            addr_q   <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            hdr_hi_q <= hdr_hi_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            to_q     <= to_d;
        end
    end

    // Control outputs are decoded from the next state and registered, so they
    // change on the same edge as the state (e.g. release coincides with DONE).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_ready_q      <= 1'b0;
            write_enable_q <= 1'b0;
            init_mode_q    <= 1'b1;
            core_reset_q   <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            s_ready_q      <= is_stream_state(state_d);
            write_enable_q <= (state_d == ST_WRITE);
            init_mode_q    <= (state_d != ST_DONE);
            core_reset_q   <= (state_d != ST_DONE);
            load_done_q    <= (state_d == ST_DONE);
            load_error_q   <= (state_d == ST_ERROR);
        end
    end

    assign s_ready          = s_ready_q;
    assign write_enable     = write_enable_q;
    assign init_mode        = init_mode_q;
    assign core_reset       = core_reset_q;
    assign load_done        = load_done_q;
    assign load_error       = load_error_q;
    assign init_address     = addr_q;
    assign init_instruction = pk_word;

endmodule

// File: doc/imem_stream_loader.md
# imem_stream_loader

Boot-time loader that drives the instruction-memory init port (`init_mode`, `write_enable`, `init_address`, `init_instruction`) of `iitk_mini_mips` from a byte stream, for example a UART receiver. It parses a 2-byte word-count header and packs 4 payload bytes per instruction word. It holds the core in init mode and reset until the image is complete, then releases it. It sits between the host-link receiver and the core's loader interface.

## Interface
Parameters:
- `DEPTH`, 4096: instruction-memory depth in words; the maximum legal word count.
- `TIMEOUT`, 1_000_000: idle cycles allowed between accepted bytes before the load aborts.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a load.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: the loader accepts a byte this cycle.
- `init_mode` out 1: to core `init_mode`.
- `write_enable` out 1: to core `write_enable`.
- `init_address` out 12: to core `init_address` (word index).
- `init_instruction` out 32: to core `init_instruction`.
- `core_reset` out 1: active-high hold on the core's `reset`.
- `load_done` out 1: level; the image was loaded and the core is released.
- `load_error` out 1: level; sticky until the next `start`.

## Operation
- Byte handshake: a byte transfers when `s_valid && s_ready`. `s_ready` is high only in HDR_HI, HDR_LO and DATA.
- States:
  - IDLE: `init_mode`=1, `core_reset`=1. `start` → HDR_HI; clear the count, address, byte index and error.
  - HDR_HI / HDR_LO: the word count N arrives MSB first. After the second byte: if N==0 or N>DEPTH → ERROR, else → DATA.
  - DATA: packs bytes MSB first (byte 0 → [31:24]). After the 4th byte → WRITE.
  - WRITE: one cycle. `write_enable`=1 with the current `init_address`/`init_instruction`. If this is word N → DONE, else `init_address`+1 and → DATA.
  - DONE: `init_mode`=0, `core_reset`=0, `load_done`=1. `start` → HDR_HI (reload; the core is re-held the next cycle).
  - ERROR: `init_mode`=1, `core_reset`=1, `load_error`=1. `start` → HDR_HI.
- `start` is ignored in HDR_HI, HDR_LO, DATA and WRITE.
- Timeout counter:
  - Counts cycles in HDR_HI, HDR_LO and DATA.
  - Clears on every accepted byte and on state entry.
  - Reaching TIMEOUT → ERROR; words already written stay in memory.
- Word counter is 13 bits so that N=4096 is representable. `init_address` never wraps within a legal load.
- `init_instruction` is held stable from the 4th byte through the WRITE cycle. It is don't-care otherwise and is not cleared.

## Timing
- Reset values:
  - State IDLE; `s_ready`=0, `write_enable`=0.
  - `init_mode`=1, `core_reset`=1.
  - `init_address`=0, `init_instruction`=0.
  - `load_done`=0, `load_error`=0.
- Reset asserted mid-load returns to IDLE next edge. No further `write_enable` is issued; partial memory contents are left as-is.
- Each word takes at least 5 cycles: 4 accept cycles plus 1 WRITE. `s_ready` is 0 during WRITE.
- Transition out of the last WRITE: `init_mode` falls, `core_reset` falls and `load_done` rises in the same cycle that the state becomes DONE. The core fetches from 0x00400000 on the following edge.
- All outputs are registered. There are no combinational paths from `s_valid`/`s_data` to any output.

## Structure
- A shared package `mips_boot_pkg` holds:
  - the state encoding typedef;
  - the `IMEM_BASE` (0x00400000) and `DMEM_BASE` (0x10010000) constants, which the memory models also use.
- One natural sub-module, `byte_packer`: a 4-byte to 32-bit shift register with a byte index and `word_valid`. The FSM, counters and timeout stay in the top.

## Test plan
- **Normal load.** Send N=2 (0x00,0x02), then 20 08 00 05 and 20 09 00 07. Required:
  - writes at address 0 = 0x20080005 and address 1 = 0x20090007;
  - exactly 2 `write_enable` pulses;
  - DONE with `init_mode`=0.
- **Backpressure gaps.** Same image, with `s_valid` toggling on random cycles. Required: identical writes, and no bytes dropped or duplicated.
- **Bad header.** N=0 (0x00,0x00) → ERROR, `load_error`=1, no writes. Repeat with N=4097 (0x10,0x01): same response.
- **Maximum load.** N=4096 with word i = i. Required: last write at `init_address` 0xFFF with data 0x00000FFF, then DONE.
- **Timeout.** Set TIMEOUT=16 and stall after 2 payload bytes. Required: ERROR on the 16th idle cycle, no `write_enable`. A following `start` plus a valid image completes normally.
- **Reset mid-load.** Drop `reset_n` after word 1 of a 3-word load. Required: next cycle in IDLE with `init_mode`=1, `core_reset`=1, `init_address`=0, and no further writes.
